// File: rtl/branch_predictor_pkg.sv
// Shared types, sizes and address-split helpers for the BTB predictor.
package branch_predictor_pkg;

  localparam int unsigned IDX_BITS = 4;
  localparam int unsigned TAG_BITS = 8;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned ENTRIES  = 1 << IDX_BITS;

  typedef logic [1:0] ctr_t;

  localparam ctr_t BP_SNT = 2'b00;
  localparam ctr_t BP_WNT = 2'b01;
  localparam ctr_t BP_WT  = 2'b10;
  localparam ctr_t BP_ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [31:0]         target;
    ctr_t                ctr;
  } btb_entry_t;

  localparam btb_entry_t BTB_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: BP_WNT};

  // Table index: PC bits just above the word offset.
  function automatic logic [IDX_BITS-1:0] bp_idx(input logic [31:0] pc);
    return IDX_BITS'(pc >> 2);
  endfunction

  // Tag: PC bits just above the index.
  function automatic logic [TAG_BITS-1:0] bp_tag(input logic [31:0] pc);
    return TAG_BITS'(pc >> (IDX_BITS + 2));
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch / execute / perf-counter signals between the pipeline and the predictor.
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  logic [31:0]      PCF;
  logic             PredictTakenF;
  logic [31:0]      PredictTargetF;
  logic             BranchE;
  logic [31:0]      PCE;
  logic             BranchTakenE;
  logic [31:0]      BranchTargetE;
  logic             PredictTakenE;
  logic [31:0]      PredictTargetE;
  logic             MispredictE;
  logic [31:0]      RedirectPCE;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] MispredictCount;

  modport slave (
    input  PCF, BranchE, PCE, BranchTakenE, BranchTargetE, PredictTakenE, PredictTargetE,
    output PredictTakenF, PredictTargetF, MispredictE, RedirectPCE, BranchCount, MispredictCount
  );

  modport master (
    output PCF, BranchE, PCE, BranchTakenE, BranchTargetE, PredictTakenE, PredictTargetE,
    input  PredictTakenF, PredictTargetF, MispredictE, RedirectPCE, BranchCount, MispredictCount
  );

endinterface

// File: rtl/bp_sat_ctr2.sv
// Two-bit saturating counter next-state function.
module bp_sat_ctr2
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr_i,
  input  logic taken_i,
  output ctr_t next_ctr_o
);

  // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
  always_comb begin
    next_ctr_o = ctr_i;
    if (taken_i && (ctr_i != BP_ST)) begin
      next_ctr_o = ctr_i + 2'd1;
    end else if (!taken_i && (ctr_i != BP_SNT)) begin
      next_ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch lookup, execute update and mispredict detection.
module branch_predictor
  import branch_predictor_pkg::*;
(
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);

  btb_entry_t       table_q [ENTRIES];
  btb_entry_t       fetch_entry;
  btb_entry_t       upd_old;
  btb_entry_t       upd_entry_d;
  logic             fetch_hit;
  logic             upd_hit;
  logic             mispredict;
  ctr_t             upd_ctr_next;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  // Fetch-side lookup; reads only registered table state, so no write-to-read bypass.
  always_comb begin
    fetch_entry       = table_q[bp_idx(bp.PCF)];
    fetch_hit         = fetch_entry.valid && (fetch_entry.tag == bp_tag(bp.PCF));
    bp.PredictTakenF  = fetch_hit && fetch_entry.ctr[1];
    bp.PredictTargetF = fetch_hit ? fetch_entry.target : (bp.PCF + 32'd4);
  end

  // Resolved-branch check and recovery PC.
  always_comb begin
    mispredict = bp.BranchE &&
                 ((bp.PredictTakenE != bp.BranchTakenE) ||
                  (bp.PredictTakenE && bp.BranchTakenE && (bp.PredictTargetE != bp.BranchTargetE)));
    bp.MispredictE = mispredict;
    bp.RedirectPCE = (bp.BranchE && bp.BranchTakenE) ? bp.BranchTargetE : (bp.PCE + 32'd4);
  end

  bp_sat_ctr2 u_sat_ctr (
    .ctr_i      (upd_old.ctr),
    .taken_i    (bp.BranchTakenE),
    .next_ctr_o (upd_ctr_next)
  );

  // New contents for the entry addressed by the resolving branch.
  always_comb begin
    upd_old     = table_q[bp_idx(bp.PCE)];
    upd_hit     = upd_old.valid && (upd_old.tag == bp_tag(bp.PCE));
    upd_entry_d = upd_old;
    if (upd_hit) begin
      upd_entry_d.ctr = upd_ctr_next;
      if (bp.BranchTakenE) begin
        upd_entry_d.target = bp.BranchTargetE;
      end
    end else if (bp.BranchTakenE) begin
      upd_entry_d = '{valid: 1'b1, tag: bp_tag(bp.PCE), target: bp.BranchTargetE, ctr: BP_WT};
    end
  end

  // Saturating performance counters.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    mis_cnt_d    = mis_cnt_q;
    if (bp.BranchE && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict && (mis_cnt_q != '1)) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  // Table and counter state; every entry is flop-based so reset can clear it at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i] <= BTB_RESET;
      end
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
    end else begin
      if (bp.BranchE) begin
        table_q[bp_idx(bp.PCE)] <= upd_entry_d;
      end
      branch_cnt_q <= branch_cnt_d;
      mis_cnt_q    <= mis_cnt_d;
    end
  end

  assign bp.BranchCount     = branch_cnt_q;
  assign bp.MispredictCount = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a behavioural BTB model.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic reset;

  branch_predictor_if bus ();

  branch_predictor dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bus)
  );

  always #5 clk = ~clk;

  localparam int unsigned CMAX = 65535;

  int checks   = 0;
  int failures = 0;

  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int unsigned m_bc;
  int unsigned m_mc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned midx(input logic [31:0] pc);
    return (pc >> 2) % 16;
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return (pc >> 6) % 256;
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit mpred_taken(input logic [31:0] pc);
    return mhit(pc) && (m_ctr[midx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] mpred_tgt(input logic [31:0] pc);
    return mhit(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic m_update(input logic [31:0] pce, input bit tk, input logic [31:0] tgt);
    int unsigned i;
    i = midx(pce);
    if (mhit(pce)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = mtag(pce);
      m_tgt[i]   = tgt;
      m_ctr[i]   = 2;
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, then model the posedge update.
  task automatic step(input logic [31:0] pcf, input bit br, input logic [31:0] pce,
                      input bit tk, input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    bit exp_mis;
    @(negedge clk);
    bus.PCF            = pcf;
    bus.BranchE        = br;
    bus.PCE            = pce;
    bus.BranchTakenE   = tk;
    bus.BranchTargetE  = tgt;
    bus.PredictTakenE  = ptk;
    bus.PredictTargetE = ptgt;
    #1;
    exp_mis = br && ((ptk != tk) || (ptk && tk && (ptgt != tgt)));
    chk("PredictTakenF", 32'(bus.PredictTakenF), 32'(mpred_taken(pcf)));
    chk("PredictTargetF", bus.PredictTargetF, mpred_tgt(pcf));
    chk("MispredictE", 32'(bus.MispredictE), 32'(exp_mis));
    if (br) chk("RedirectPCE", bus.RedirectPCE, tk ? tgt : pce + 32'd4);
    chk("BranchCount", 32'(bus.BranchCount), m_bc);
    chk("MispredictCount", 32'(bus.MispredictCount), m_mc);
    if (br) begin
      m_update(pce, tk, tgt);
      if (m_bc < CMAX) m_bc++;
      if (exp_mis && (m_mc < CMAX)) m_mc++;
    end
  endtask

  // Fetch-only cycle.
  task automatic look(input logic [31:0] pcf);
    step(pcf, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Resolve a branch with the prediction the model would have made for it at fetch.
  task automatic resolve(input logic [31:0] pcf, input logic [31:0] pce, input bit tk,
                         input logic [31:0] tgt);
    step(pcf, 1'b1, pce, tk, tgt, mpred_taken(pce), mpred_tgt(pce));
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] pcf, pce, tgt, ptgt;
    bit          br, tk, ptk;

    pool = '{32'h100, 32'h140, 32'h180, 32'h1c0, 32'h104, 32'h2040, 32'h4100, 32'h3c};

    reset              = 1'b0;
    bus.PCF            = 32'h100;
    bus.BranchE        = 1'b0;
    bus.PCE            = '0;
    bus.BranchTakenE   = 1'b0;
    bus.BranchTargetE  = '0;
    bus.PredictTakenE  = 1'b0;
    bus.PredictTargetE = '0;
    m_reset();
    #1;
    chk("rst_PredictTakenF", 32'(bus.PredictTakenF), 32'h0);
    chk("rst_PredictTargetF", bus.PredictTargetF, 32'h104);
    chk("rst_MispredictE", 32'(bus.MispredictE), 32'h0);
    chk("rst_BranchCount", 32'(bus.BranchCount), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Cold lookup, then first taken branch mispredicted as not-taken.
    look(32'h100);
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    chk("first_redirect", bus.RedirectPCE, 32'h200);
    chk("first_mispredict", 32'(bus.MispredictE), 32'h1);
    look(32'h100);
    chk("alloc_taken", 32'(bus.PredictTakenF), 32'h1);
    chk("alloc_target", bus.PredictTargetF, 32'h200);

    // Train to ST, then walk down through WT (still taken) to WNT (not taken).
    repeat (3) resolve(32'h100, 32'h100, 1'b1, 32'h200);
    resolve(32'h100, 32'h100, 1'b0, 32'h200);
    look(32'h100);
    chk("wt_taken", 32'(bus.PredictTakenF), 32'h1);
    resolve(32'h100, 32'h100, 1'b0, 32'h200);
    look(32'h100);
    chk("wnt_not_taken", 32'(bus.PredictTakenF), 32'h0);
    chk("wnt_target", bus.PredictTargetF, 32'h200);

    // Aliasing: 0x140 shares the index of 0x100 and evicts it.
    resolve(32'h100, 32'h140, 1'b1, 32'h280);
    look(32'h100);
    chk("evicted_taken", 32'(bus.PredictTakenF), 32'h0);
    chk("evicted_target", bus.PredictTargetF, 32'h104);

    // Same-cycle lookup and update on the same index: old entry, then new one.
    resolve(32'h140, 32'h140, 1'b1, 32'h300);
    chk("same_cycle_old", bus.PredictTargetF, 32'h280);
    look(32'h140);
    chk("next_cycle_new", bus.PredictTargetF, 32'h300);

    // Randomized traffic over a small PC pool so entries collide and retrain.
    for (int n = 0; n < 400; n++) begin
      pcf = pool[$urandom_range(0, 7)];
      pce = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hffff_fffc) : pool[$urandom_range(0, 7)];
      br  = ($urandom_range(0, 4) != 0);
      tk  = $urandom_range(0, 1);
      tgt = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        ptk  = mpred_taken(pce);
        ptgt = mpred_tgt(pce);
      end else begin
        ptk  = $urandom_range(0, 1);
        ptgt = $urandom_range(0, 1) ? tgt : tgt + 32'd4;
      end
      step(pcf, br, pce, tk, tgt, ptk, ptgt);
    end

    // Counter saturation: constant mispredicted branch for 2**16+5 edges.
    @(negedge clk);
    bus.PCF            = 32'h380;
    bus.BranchE        = 1'b1;
    bus.PCE            = 32'h380;
    bus.BranchTakenE   = 1'b1;
    bus.BranchTargetE  = 32'h400;
    bus.PredictTakenE  = 1'b0;
    bus.PredictTargetE = 32'h384;
    repeat (65541) begin
      @(posedge clk);
      m_update(32'h380, 1'b1, 32'h400);
      if (m_bc < CMAX) m_bc++;
      if (m_mc < CMAX) m_mc++;
    end
    @(negedge clk);
    bus.BranchE = 1'b0;
    #1;
    chk("sat_BranchCount", 32'(bus.BranchCount), m_bc);
    chk("sat_BranchCount_ones", 32'(bus.BranchCount), 32'hffff);
    chk("sat_MispredictCount", 32'(bus.MispredictCount), 32'hffff);
    chk("sat_entry_taken", 32'(bus.PredictTakenF), 32'(mpred_taken(32'h380)));

    // Asynchronous reset mid-run clears everything without a clock edge.
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    chk("arst_BranchCount", 32'(bus.BranchCount), 32'h0);
    chk("arst_MispredictCount", 32'(bus.MispredictCount), 32'h0);
    chk("arst_PredictTakenF", 32'(bus.PredictTakenF), 32'h0);
    chk("arst_PredictTargetF", bus.PredictTargetF, 32'h384);
    @(negedge clk);
    reset = 1'b1;

    // First edge after release is an ordinary update.
    step(32'h380, 1'b1, 32'h380, 1'b1, 32'h500, 1'b0, 32'h384);
    look(32'h380);
    chk("post_rst_alloc", bus.PredictTargetF, 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
